// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data RAM with fixed multi-cycle access latency,
// branch resolution and the MEM/WB register, with stall/bubble on long accesses.
module mem_stage #(
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Zero,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_ReadData2,
  input  logic [31:0] in_BranchAddress,
  input  logic        in_CtrlMemRead,
  input  logic        in_CtrlMemWrite,
  input  logic        in_CtrlALUOrMem,
  input  logic        in_CtrlBranchEquals,
  input  logic        in_CtrlBranchNotEquals,
  input  logic        in_CtrlRegWrite,
  input  logic [4:0]  in_WriteReg,
  output logic        out_Stall,
  output logic        out_PCSrc,
  output logic [31:0] out_BranchTarget,
  output logic        out_Flush,
  output logic [31:0] out_ReadData,
  output logic [31:0] out_ALUResult,
  output logic [4:0]  out_WriteReg,
  output logic        out_CtrlRegWrite,
  output logic        out_CtrlALUOrMem,
  output logic        out_AddrFault
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 32'd1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = (MEM_LATENCY > 32'd1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((MEM_LATENCY >= 32'd2) ? (MEM_LATENCY - 32'd2) : 32'd0);
  localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      mem_q [MEM_DEPTH];

  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwr_q, regwr_d;
  logic        aom_q, aom_d;
  logic        fault_q, fault_d;

  logic             memop_s, is_load_s, is_store_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] index_s;
  logic             fault_s, start_s, stall_s, complete_s;

  // Request decode and address range/alignment check
  always_comb begin
    memop_s    = in_CtrlMemRead | in_CtrlMemWrite;
    is_store_s = in_CtrlMemWrite;
    is_load_s  = in_CtrlMemRead & ~in_CtrlMemWrite;
    offset_s   = in_ALUResult - BASE_ADDR;
    index_s    = offset_s[IDX_W+1:2];
    fault_s    = memop_s & ((offset_s[1:0] != 2'b00) |
                            (in_ALUResult < BASE_ADDR) |
                            (offset_s[31:2] >= DEPTH_WORDS));
    start_s    = (state_q == ST_IDLE) & memop_s & ~fault_s;
  end

  // Stall and completion decode from the access state
  always_comb begin
    stall_s    = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          if (MEM_LATENCY > 32'd1) begin
            stall_s = 1'b1;
          end else begin
            complete_s = 1'b1;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          stall_s = 1'b1;
        end else begin
          complete_s = 1'b1;
        end
      end
      default: begin
        stall_s    = 1'b0;
        complete_s = 1'b0;
      end
    endcase
  end

  // Stall is masked during reset so upstream never freezes on a cleared stage
  assign out_Stall        = stall_s & ~reset;
  assign out_PCSrc        = ~memop_s & ((in_CtrlBranchEquals & in_Zero) |
                                        (in_CtrlBranchNotEquals & ~in_Zero));
  assign out_Flush        = out_PCSrc;
  assign out_BranchTarget = in_BranchAddress;

  // MEM/WB next state: bubble while stalled, otherwise load from EX/MEM
  always_comb begin
    rd_data_d = rd_data_q;
    alu_d     = alu_q;
    wreg_d    = wreg_q;
    aom_d     = aom_q;
    regwr_d   = 1'b0;
    fault_d   = fault_q | fault_s;
    if (stall_s) begin
      regwr_d = 1'b0;
    end else begin
      alu_d   = in_ALUResult;
      wreg_d  = in_WriteReg;
      aom_d   = in_CtrlALUOrMem;
      regwr_d = in_CtrlRegWrite & ~fault_s;
      if (complete_s & is_load_s & ~fault_s) begin
        rd_data_d = mem_q[index_s];
      end else begin
        rd_data_d = 32'h0000_0000;
      end
    end
  end

  // Access FSM, latency counter and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rd_data_q <= 32'h0000_0000;
      alu_q     <= 32'h0000_0000;
      wreg_q    <= 5'd0;
      regwr_q   <= 1'b0;
      aom_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s && (MEM_LATENCY > 32'd1)) begin
            state_q <= ST_BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
      rd_data_q <= rd_data_d;
      alu_q     <= alu_d;
      wreg_q    <= wreg_d;
      regwr_q   <= regwr_d;
      aom_q     <= aom_d;
      fault_q   <= fault_d;
    end
  end

  // Data RAM write port; contents survive reset, aborted accesses never write
  always_ff @(posedge clk) begin
    if (!reset && complete_s && is_store_s && !fault_s) begin
      mem_q[index_s] <= in_ReadData2;
    end
  end

  assign out_ReadData     = rd_data_q;
  assign out_ALUResult    = alu_q;
  assign out_WriteReg     = wreg_q;
  assign out_CtrlRegWrite = regwr_q;
  assign out_CtrlALUOrMem = aom_q;
  assign out_AddrFault    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: two instances (latency 2 and 1) checked
// against a transaction-level model of RAM contents and MEM/WB results.
module tb_mem_stage;

  localparam logic [31:0] BASE = 32'h1001_0000;

  typedef struct packed {
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] baddr;
    logic        mrd;
    logic        mwr;
    logic        aom;
    logic        beq;
    logic        bne;
    logic        rw;
    logic [4:0]  wreg;
  } in_t;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  in_t  bus, in0, in1;

  always #5 clk = ~clk;

  assign in0 = sel ? in_t'(0) : bus;
  assign in1 = sel ? bus : in_t'(0);

  logic        st_w  [2];
  logic        pcs_w [2];
  logic [31:0] bt_w  [2];
  logic        fl_w  [2];
  logic [31:0] rd_w  [2];
  logic [31:0] alu_w [2];
  logic [4:0]  wr_w  [2];
  logic        rw_w  [2];
  logic        aom_w [2];
  logic        af_w  [2];

  mem_stage #(.MEM_DEPTH(64), .MEM_LATENCY(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .in_Zero(in0.zero), .in_ALUResult(in0.alu),
    .in_ReadData2(in0.rd2), .in_BranchAddress(in0.baddr),
    .in_CtrlMemRead(in0.mrd), .in_CtrlMemWrite(in0.mwr),
    .in_CtrlALUOrMem(in0.aom), .in_CtrlBranchEquals(in0.beq),
    .in_CtrlBranchNotEquals(in0.bne), .in_CtrlRegWrite(in0.rw),
    .in_WriteReg(in0.wreg), .out_Stall(st_w[0]), .out_PCSrc(pcs_w[0]),
    .out_BranchTarget(bt_w[0]), .out_Flush(fl_w[0]), .out_ReadData(rd_w[0]),
    .out_ALUResult(alu_w[0]), .out_WriteReg(wr_w[0]),
    .out_CtrlRegWrite(rw_w[0]), .out_CtrlALUOrMem(aom_w[0]),
    .out_AddrFault(af_w[0]));

  mem_stage #(.MEM_DEPTH(64), .MEM_LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .in_Zero(in1.zero), .in_ALUResult(in1.alu),
    .in_ReadData2(in1.rd2), .in_BranchAddress(in1.baddr),
    .in_CtrlMemRead(in1.mrd), .in_CtrlMemWrite(in1.mwr),
    .in_CtrlALUOrMem(in1.aom), .in_CtrlBranchEquals(in1.beq),
    .in_CtrlBranchNotEquals(in1.bne), .in_CtrlRegWrite(in1.rw),
    .in_WriteReg(in1.wreg), .out_Stall(st_w[1]), .out_PCSrc(pcs_w[1]),
    .out_BranchTarget(bt_w[1]), .out_Flush(fl_w[1]), .out_ReadData(rd_w[1]),
    .out_ALUResult(alu_w[1]), .out_WriteReg(wr_w[1]),
    .out_CtrlRegWrite(rw_w[1]), .out_CtrlALUOrMem(aom_w[1]),
    .out_AddrFault(af_w[1]));

  int lat [2] = '{2, 1};

  // reference model: RAM image and expected MEM/WB contents per instance
  logic [31:0] ram_m [2][64];
  logic [31:0] e_rd  [2];
  logic [31:0] e_alu [2];
  logic [4:0]  e_wr  [2];
  logic        e_rw  [2];
  logic        e_aom [2];
  logic        e_af  [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_mewb(input int d);
    check_eq($sformatf("rd%0d", d),  rd_w[d],         e_rd[d]);
    check_eq($sformatf("alu%0d", d), alu_w[d],        e_alu[d]);
    check_eq($sformatf("wr%0d", d),  32'(wr_w[d]),    32'(e_wr[d]));
    check_eq($sformatf("rw%0d", d),  32'(rw_w[d]),    32'(e_rw[d]));
    check_eq($sformatf("aom%0d", d), 32'(aom_w[d]),   32'(e_aom[d]));
    check_eq($sformatf("af%0d", d),  32'(af_w[d]),    32'(e_af[d]));
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      e_rd[d] = 32'h0; e_alu[d] = 32'h0; e_wr[d] = 5'd0;
      e_rw[d] = 1'b0;  e_aom[d] = 1'b0;  e_af[d] = 1'b0;
    end
  endtask

  // the unselected instance sees an all-zero (no-op) input every cycle
  task automatic idle_update(input int d);
    e_rd[d] = 32'h0; e_alu[d] = 32'h0; e_wr[d] = 5'd0;
    e_rw[d] = 1'b0;  e_aom[d] = 1'b0;
  endtask

  task automatic do_op(input in_t op);
    int          d;
    logic        memop, fault, exp_pc;
    logic [31:0] off;
    int          idx, nst;
    d     = sel ? 1 : 0;
    bus   = op;
    #1;
    memop = op.mrd | op.mwr;
    off   = op.alu - BASE;
    idx   = int'(off >> 2);
    fault = memop && ((op.alu % 4) != 0 || op.alu < BASE || (off / 4) >= 64);
    exp_pc = memop ? 1'b0 : ((op.beq && op.zero) || (op.bne && !op.zero));
    check_eq("pcsrc", 32'(pcs_w[d]), 32'(exp_pc));
    check_eq("flush", 32'(fl_w[d]), 32'(exp_pc));
    check_eq("target", bt_w[d], op.baddr);
    nst = (memop && !fault) ? lat[d] - 1 : 0;
    for (int k = 0; k < nst; k++) begin
      check_eq("stall_hi", 32'(st_w[d]), 32'd1);
      @(posedge clk); #1;
      e_rw[d] = 1'b0;
      idle_update(1 - d);
      check_mewb(d);
    end
    check_eq("stall_lo", 32'(st_w[d]), 32'd0);
    @(posedge clk); #1;
    e_alu[d] = op.alu;
    e_wr[d]  = op.wreg;
    e_aom[d] = op.aom;
    e_rw[d]  = op.rw && !fault;
    e_rd[d]  = (op.mrd && !op.mwr && !fault) ? ram_m[d][idx] : 32'h0;
    if (op.mwr && !fault) ram_m[d][idx] = op.rd2;
    if (fault) e_af[d] = 1'b1;
    idle_update(1 - d);
    check_mewb(d);
  endtask

  function automatic in_t mk_mem(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] data);
    in_t op;
    op = in_t'(0);
    op.mrd = rd; op.mwr = wr; op.alu = a; op.rd2 = data;
    return op;
  endfunction

  function automatic in_t mk_rand();
    in_t op;
    int  k;
    op       = in_t'(0);
    op.zero  = 1'($urandom);
    op.rd2   = $urandom;
    op.baddr = $urandom;
    op.aom   = 1'($urandom);
    op.beq   = 1'($urandom);
    op.bne   = 1'($urandom);
    op.rw    = 1'($urandom);
    op.wreg  = 5'($urandom);
    op.alu   = BASE + 32'($urandom_range(0, 63)) * 32'd4;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: op.mrd = 1'b1;
      3, 4:    op.mwr = 1'b1;
      5:       begin op.mrd = 1'b1; op.mwr = 1'b1; end
      6: begin
        op.mrd = 1'($urandom);
        op.mwr = ~op.mrd;
        case ($urandom_range(0, 2))
          0:       op.alu = op.alu + 32'($urandom_range(1, 3));
          1:       op.alu = BASE - 32'd4 * 32'($urandom_range(1, 8));
          default: op.alu = BASE + 32'h100 + 32'd4 * 32'($urandom_range(0, 8));
        endcase
      end
      default: op.alu = $urandom;
    endcase
    return op;
  endfunction

  initial begin
    in_t op;
    reset = 1'b1;
    sel   = 1'b0;
    bus   = in_t'(0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall0", 32'(st_w[0]), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rel_stall0", 32'(st_w[0]), 32'd0);
    check_mewb(0);
    check_mewb(1);
    @(posedge clk); #1;
    check_eq("post_stall0", 32'(st_w[0]), 32'd0);
    check_mewb(0);

    // fill both RAMs so every later load has a known value
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 64; i++)
        do_op(mk_mem(1'b0, 1'b1, BASE + 32'(i) * 32'd4, $urandom));
    end

    // directed store/load on the latency-2 instance
    sel = 1'b0;
    do_op(mk_mem(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF));
    op = mk_mem(1'b1, 1'b0, 32'h1001_0008, 32'h0);
    op.rw = 1'b1; op.wreg = 5'd8; op.aom = 1'b1;
    do_op(op);
    check_eq("ld_deadbeef", rd_w[0], 32'hDEAD_BEEF);

    // branches
    op = in_t'(0); op.beq = 1'b1; op.zero = 1'b1; op.baddr = 32'h0040_0020;
    do_op(op);
    op.zero = 1'b0; do_op(op);
    op = in_t'(0); op.bne = 1'b1; op.zero = 1'b0; op.baddr = 32'h0040_0020;
    do_op(op);
    op.zero = 1'b1; do_op(op);

    // faulting accesses
    op = mk_mem(1'b1, 1'b0, 32'h1001_0002, 32'h0); op.rw = 1'b1;
    do_op(op);
    do_op(mk_mem(1'b0, 1'b1, 32'h1001_0100, 32'h1234_5678));
    do_op(mk_mem(1'b1, 1'b0, 32'h1001_00FC, 32'h0));

    // reset during the stall cycle of a store aborts it
    bus = mk_mem(1'b0, 1'b1, 32'h1001_0014, 32'hCAFE_F00D);
    #1;
    check_eq("abort_stall", 32'(st_w[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_rst_stall", 32'(st_w[0]), 32'd0);
    bus   = in_t'(0);
    reset = 1'b0;
    #1;
    check_eq("abort_next_stall", 32'(st_w[0]), 32'd0);
    clear_model();
    check_mewb(0);
    check_mewb(1);
    do_op(mk_mem(1'b1, 1'b0, 32'h1001_0014, 32'h0));

    // back-to-back loads on both latencies
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_op(mk_mem(1'b1, 1'b0, 32'h1001_0020, 32'h0));
      do_op(mk_mem(1'b1, 1'b0, 32'h1001_0024, 32'h0));
    end

    // randomized mix across both instances
    for (int i = 0; i < 400; i++) begin
      sel = 1'($urandom);
      do_op(mk_rand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
